// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM port arbiter.
//   ramstate_t  : status code returned by the RAM model on its 2-bit ramstate bus
//   arb_state_t : arbiter FSM state, also exported on the arbiter's debug port
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IGRANT = 2'd1,
    ARB_DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter that tracks how many data grants in a row have completed
// while an instruction fetch was waiting.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one more data completion (holds at LIMIT)
//   clr        : return to zero (wins over inc)
//   sat        : count has reached LIMIT
//   cnt        : current count
module mem_arbiter_starve_counter #(
  parameter int LIMIT = 4,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic             sat,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat = (cnt_q == CNT_W'(LIMIT));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one RAM port between instruction fetch (i side) and
// load/store (d side). Data wins ties unless the instruction side has already
// waited through STARVE_LIMIT consecutive data completions.
//
// Handshake: a requester raises iREN (or dREN/dWEN) with address/data and
// holds everything stable while its wait output is high. The cycle its wait
// output is low is the single completion cycle; read data is valid only then.
// Dropping all request lines before completion aborts with no completion.
// On ERROR, err pulses and wait stays high; the requester simply keeps
// requesting and is re-arbitrated.
//
// Ports:
//   CLK, nRST                    clock, asynchronous active-low reset
//   iREN, iaddr, iload, iwait    instruction requester
//   dREN, dWEN, daddr, dstore,
//   dload, dwait                 data requester
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload, ramstate  RAM port
//   err                          one-cycle pulse on an ERROR completion
//   dbg_state, dbg_starve_cnt    FSM state and starvation count for observation
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              iREN,
  input  logic [ADDR_W-1:0]                 iaddr,
  output logic [DATA_W-1:0]                 iload,
  output logic                              iwait,
  input  logic                              dREN,
  input  logic                              dWEN,
  input  logic [ADDR_W-1:0]                 daddr,
  input  logic [DATA_W-1:0]                 dstore,
  output logic [DATA_W-1:0]                 dload,
  output logic                              dwait,
  output logic                              ramREN,
  output logic                              ramWEN,
  output logic [ADDR_W-1:0]                 ramaddr,
  output logic [DATA_W-1:0]                 ramstore,
  input  logic [DATA_W-1:0]                 ramload,
  input  logic [1:0]                        ramstate,
  output logic                              err,
  output arb_state_t                        dbg_state,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] dbg_starve_cnt
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t state_q;
  arb_state_t state_d;
  ramstate_t  ram_st;
  logic       starve_inc;
  logic       starve_clr;
  logic       starve_sat;

  assign ram_st    = ramstate_t'(ramstate);
  assign dbg_state = state_q;

  mem_arbiter_starve_counter #(
    .LIMIT(STARVE_LIMIT),
    .CNT_W(CNT_W)
  ) u_starve (
    .clk  (CLK),
    .rst_n(nRST),
    .inc  (starve_inc),
    .clr  (starve_clr),
    .sat  (starve_sat),
    .cnt  (dbg_starve_cnt)
  );

  // Outputs are decoded from the held grant plus the live request inputs, so
  // an asynchronous reset of state_q drops the RAM enables immediately.
  always_comb begin
    state_d    = state_q;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    err        = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if ((dREN || dWEN) && !(iREN && starve_sat)) begin
          state_d = ARB_DGRANT;
        end else if (iREN) begin
          state_d = ARB_IGRANT;
        end
      end

      ARB_DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;  // write wins when both are raised
        if (!dREN && !dWEN) begin
          state_d = ARB_IDLE;
        end else if (ram_st == ACCESS) begin
          dwait   = 1'b0;
          dload   = dWEN ? '0 : ramload;
          state_d = ARB_IDLE;
          // Only completions move the starvation count.
          if (iREN) begin
            starve_inc = 1'b1;
          end else begin
            starve_clr = 1'b1;
          end
        end else if (ram_st == ERROR) begin
          err     = 1'b1;
          state_d = ARB_IDLE;
        end
      end

      ARB_IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = ARB_IDLE;
        end else if (ram_st == ACCESS) begin
          iwait      = 1'b0;
          iload      = ramload;
          starve_clr = 1'b1;
          state_d    = ARB_IDLE;
        end else if (ram_st == ERROR) begin
          err     = 1'b1;
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
